ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute-stage wrapper that sits between the decode/register-read stage and writeback.
- Latches a decoded operation and its operands, then resolves read-after-write hazards by forwarding.
- Drives the combinational ALU's opcode/left/right inputs, captures the ALU result in an output register and presents it downstream.
- Uses valid/ready handshakes on both sides; two-entry pipeline (operand register, result register); sustains one op per cycle.

Parameters:
- DW, 32, datapath width; must match ALU width.
- RW, 4, register index width (16 GPRs).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  stage accepts the op this cycle.
- in_op  in  4  ALU opcode.
- in_rd  in  RW  destination register.
- in_we  in  1  op writes in_rd.
- in_ra  in  RW  left source register index.
- in_rb  in  RW  right source register index.
- in_a  in  DW  register-file value of ra.
- in_b  in  DW  register-file value of rb.
- in_imm_sel  in  1  right operand is in_imm, not rb.
- in_imm  in  DW  immediate.
- alu_opcode  out  4  to ALU.
- alu_left  out  DW  to ALU.
- alu_right  out  DW  to ALU.
- alu_out  in  DW  from ALU, combinational on the above.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  writeback accepts.
- out_rd  out  RW  destination of held result.
- out_we  out  1  held result writes out_rd.
- out_data  out  DW  held result.
- wb_en  in  1  register-file write this cycle; equals out_valid & out_ready & out_we.
- wb_rd  in  RW  write index.
- wb_data  in  DW  write data.

Behaviour:
- Reset (async, rst_n low):
  - op_valid=0, out_valid=0.
  - out_rd, out_we, out_data and all operand registers = 0.
  - in_ready=1 once reset deasserts.
  - Reset mid-operation discards both entries; no handshake completes on a reset cycle.
- Fires:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - adv = op_valid & (!out_valid | out_ready).
- in_ready = !op_valid | adv (pass-through ready; a full stage accepts when it advances).
- Operand register load on in_fire:
  - Captures op, rd, we, ra, rb, imm_sel.
  - a = wb_en & wb_rd==in_ra ? wb_data : in_a.
  - b = imm_sel ? in_imm : (wb_en & wb_rd==in_rb ? wb_data : in_b).
  - op_valid set on in_fire, cleared on adv without in_fire.
- Operand refresh while held (op_valid & !adv): if wb_en & wb_rd==ra, a <= wb_data; same for b when !imm_sel.
- ALU drive:
  - alu_opcode = op.
  - alu_left = (out_valid & out_we & out_rd==ra) ? out_data : a.
  - alu_right = !imm_sel & (out_valid & out_we & out_rd==rb) ? out_data : b.
  - ALU outputs are don't-care when !op_valid.
- Result register:
  - On adv: out_data <= alu_out; out_rd, out_we copied; out_valid <= 1.
  - On out_fire without adv: out_valid <= 0.
- Priority: result-register bypass beats operand register; wb port beats register-file value. Register 0 is not special.
- Latency: op accepted at edge E0 appears on out_* after edge E1 when unstalled. Throughput one per cycle.
- Back-pressure: out_ready low holds both entries stable; in_ready falls once the operand register is full.
- Simultaneous in_fire and adv: new op replaces old in the same edge, old op moves to result register.

Optional Feature:
- Macro EX_FORWARD_EN.
- Defined: wb capture-forwarding, operand refresh and result-register bypass as above.
- Undefined:
  - alu_left = a, alu_right = b.
  - a/b loaded from in_a/in_b/in_imm only; no refresh.
  - Decode must interlock on hazards; all other timing is identical.

Test Plan:
- Reset then single op: op=0010, in_a=5, in_b=7, rd=3, out_ready=1 -> out_valid one cycle after accept, out_data=12, out_rd=3, out_we=1.
- Back-to-back dependency (EX_FORWARD_EN): add r1=2+3 then sub r2=r1-1 with stale in_a=0 -> second out_data=4 via result-register bypass; without macro, out_data=0xFFFFFFFF.
- Held operand refresh: out_ready=0 for 3 cycles with op in operand register needing r4; wb_en, wb_rd=4, wb_data=0x10 pulses -> result uses 0x10; in_ready=0 while both entries are full.
- Immediate select: in_imm_sel=1, in_imm=0x0000FFFF, rb matches out_rd -> alu_right=0x0000FFFF, no bypass on right.
- Stream of 8 ops with out_ready toggling 1,0,1,0 -> no op lost or duplicated, order preserved, in_ready matches rule every cycle.
- rst_n asserted while both entries valid -> out_valid=0 and in_ready=1 immediately after release; no output fire.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand and result registers, valid/ready on both sides.
// Define EX_FORWARD_EN to enable writeback capture/refresh forwarding and result-register bypass.
module ex_stage #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  input  logic [RW-1:0] in_ra,
  input  logic [RW-1:0] in_rb,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_imm_sel,
  input  logic [DW-1:0] in_imm,
  output logic [3:0]    alu_opcode,
  output logic [DW-1:0] alu_left,
  output logic [DW-1:0] alu_right,
  input  logic [DW-1:0] alu_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_rd,
  output logic          out_we,
  output logic [DW-1:0] out_data,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data
);
  logic          r_op_valid, r_we, r_imm_sel, r_out_valid, r_out_we;
  logic [3:0]    r_op;
  logic [RW-1:0] r_rd, r_ra, r_rb, r_out_rd;
  logic [DW-1:0] r_a, r_b, r_out_data;
  logic          w_in_fire, w_out_fire, w_adv;
  logic [DW-1:0] w_a_in, w_b_in, w_a_hold, w_b_hold;

  assign w_adv      = r_op_valid & (!r_out_valid | out_ready);
  assign in_ready   = !r_op_valid | w_adv;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;

`ifdef EX_FORWARD_EN
  // The newest producer wins: result register over operand register, wb port over register file.
  assign w_a_in    = (wb_en && wb_rd == in_ra) ? wb_data : in_a;
  assign w_b_in    = in_imm_sel ? in_imm : (wb_en && wb_rd == in_rb) ? wb_data : in_b;
  assign w_a_hold  = (wb_en && wb_rd == r_ra) ? wb_data : r_a;
  assign w_b_hold  = (!r_imm_sel && wb_en && wb_rd == r_rb) ? wb_data : r_b;
  assign alu_left  = (r_out_valid && r_out_we && r_out_rd == r_ra) ? r_out_data : r_a;
  assign alu_right = (!r_imm_sel && r_out_valid && r_out_we && r_out_rd == r_rb) ? r_out_data : r_b;
`else
  logic w_unused;
  assign w_unused  = ^{wb_en, wb_rd, wb_data, r_ra, r_rb, r_imm_sel};
  assign w_a_in    = in_a;
  assign w_b_in    = in_imm_sel ? in_imm : in_b;
  assign w_a_hold  = r_a;
  assign w_b_hold  = r_b;
  assign alu_left  = r_a;
  assign alu_right = r_b;
`endif

  assign alu_opcode = r_op;
  assign out_valid  = r_out_valid;
  assign out_rd     = r_out_rd;
  assign out_we     = r_out_we;
  assign out_data   = r_out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_valid  <= 1'b0;
      r_op        <= '0;
      r_rd        <= '0;
      r_we        <= 1'b0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_imm_sel   <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_out_valid <= 1'b0;
      r_out_rd    <= '0;
      r_out_we    <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_op_valid <= w_in_fire | (r_op_valid & !w_adv);
      if (w_in_fire) begin
        r_op      <= in_op;
        r_rd      <= in_rd;
        r_we      <= in_we;
        r_ra      <= in_ra;
        r_rb      <= in_rb;
        r_imm_sel <= in_imm_sel;
        r_a       <= w_a_in;
        r_b       <= w_b_in;
      end else if (r_op_valid && !w_adv) begin
        r_a <= w_a_hold;
        r_b <= w_b_hold;
      end
      if (w_adv) begin
        r_out_valid <= 1'b1;
        r_out_data  <= alu_out;
        r_out_rd    <= r_rd;
        r_out_we    <= r_we;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule
